register_file_mp: RTL and testbench

REGISTER_FILE_MP -- requirements
Module: register_file_mp

---
 rtl/register_file_mp_pkg.sv | 6 +
 rtl/rf_read_port.sv | 26 ++
 rtl/register_file_mp.sv | 73 +++++++
 tb/tb_register_file_mp.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/register_file_mp_pkg.sv
// register_file_mp_pkg: shared state encoding and well-known register indices
package register_file_mp_pkg;
  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1} state_t;
  localparam int ZERO_REG_IDX = 30;
  localparam int RA_REG_IDX = 31;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port with zero-register masking and write forwarding
module rf_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ZERO_REG = 30,
  parameter int BYPASS = 1
) (
  input  logic              ready,
  input  logic [DATA_W-1:0] mem [2**ADDR_W],
  input  logic [ADDR_W-1:0] ra,
  input  logic              w0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              w1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] rd
);
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);
  localparam bit BP = BYPASS != 0;
  // port 1 is checked first so it wins a same-address double write
  always_comb
    rd = (!ready || ra == ZA) ? '0 :
         (BP && w1 && wa1 == ra) ? wd1 :
         (BP && w0 && wa0 == ra) ? wd0 : mem[ra];
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: two-write multi-read register file with zeroing sweep after reset/clear
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = ZERO_REG_IDX,
  parameter int BYPASS = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  output logic                     ready,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd0,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST = '1;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic w0, w1;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= INIT;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  // unused encodings fall through the INIT branch and recover via the sweep
  always_comb begin
    state_nx = clear ? INIT : state == RUN ? RUN : cnt == LAST ? RUN : INIT;
    cnt_nx = (clear || state == RUN) ? '0 : cnt + 1'b1;
  end
  always_comb ready = state == RUN;
  assign w0 = ready && !clear && we0 && wa0 != ZA;
  assign w1 = ready && !clear && we1 && wa1 != ZA;
  // storage has no reset; the sweep zeroes it one entry per cycle
  always_ff @(posedge clock)
    if (!ready) mem[cnt] <= '0;
    else begin
      if (w0) mem[wa0] <= wd0;
      if (w1) mem[wa1] <= wd1;
    end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS(BYPASS)
    ) u_rp (
      .ready(ready),
      .mem(mem),
      .ra(ra[i*ADDR_W +: ADDR_W]),
      .w0(w0),
      .wa0(wa0),
      .wd0(wd0),
      .w1(w1),
      .wa1(wa1),
      .wd1(wd1),
      .rd(rd[i*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed table-driven bench for forwarding and non-forwarding builds
module tb_register_file_mp;
  import register_file_mp_pkg::*;
  typedef struct {
    logic we0; logic [4:0] wa0; logic [31:0] wd0;
    logic we1; logic [4:0] wa1; logic [31:0] wd1;
    logic [4:0] ra0, ra1;
    logic [31:0] b0, b1, n0, n1;
  } vec_t;
  logic clock = 0, reset = 0, clear = 0, we0 = 0, we1 = 0;
  logic [4:0] wa0 = 0, wa1 = 0, ra0 = 0, ra1 = 0;
  logic [31:0] wd0 = 0, wd1 = 0;
  logic [9:0] ra_bus;
  logic [63:0] rd_b, rd_n;
  logic ready_b, ready_n;
  int checks = 0, failures = 0;
  vec_t vecs [11];
  assign ra_bus = {ra1, ra0};
  always #5 clock = ~clock;
  register_file_mp #(.BYPASS(1)) dut (
    .clock(clock), .reset(reset), .clear(clear), .ready(ready_b),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .ra(ra_bus), .rd(rd_b)
  );
  register_file_mp #(.BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset), .clear(clear), .ready(ready_n),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .ra(ra_bus), .rd(rd_n)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic wait_ready(input string name);
    int n = 0;
    tick();
    n++;
    while (!ready_b && n < 100) begin
      tick();
      n++;
    end
    chk(name, n, 32);
    chk({name, "_nb"}, {31'd0, ready_n}, 1);
  endtask
  task automatic check_all_zero(input string name);
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a);
      ra1 = 5'(31 - a);
      #1;
      chk($sformatf("%s_b0_a%0d", name, a), rd_b[31:0], 0);
      chk($sformatf("%s_b1_a%0d", name, a), rd_b[63:32], 0);
      chk($sformatf("%s_n0_a%0d", name, a), rd_n[31:0], 0);
      chk($sformatf("%s_n1_a%0d", name, a), rd_n[63:32], 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vecs[0]  = '{1, 5,  32'hDEADBEEF, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    vecs[1]  = '{0, 0,  0, 0, 0, 0, 5, 7, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    vecs[2]  = '{1, 7,  1, 1, 7, 2, 7, 5, 2, 32'hDEADBEEF, 0, 32'hDEADBEEF};
    vecs[3]  = '{0, 0,  0, 0, 0, 0, 7, 7, 2, 2, 2, 2};
    vecs[4]  = '{1, 5'(ZERO_REG_IDX), 32'hFFFFFFFF, 1, 5'(RA_REG_IDX), 32'h1234,
                 5'(ZERO_REG_IDX), 5'(RA_REG_IDX), 0, 32'h1234, 0, 0};
    vecs[5]  = '{0, 0,  0, 0, 0, 0, 30, 31, 0, 32'h1234, 0, 32'h1234};
    vecs[6]  = '{1, 3,  32'h55, 1, 30, 32'hABCD, 30, 3, 0, 32'h55, 0, 0};
    vecs[7]  = '{0, 0,  0, 0, 0, 0, 3, 30, 32'h55, 0, 32'h55, 0};
    vecs[8]  = '{1, 5,  32'h11, 1, 6, 32'h22, 5, 6, 32'h11, 32'h22, 32'hDEADBEEF, 0};
    vecs[9]  = '{0, 3,  32'h99, 1, 3, 32'h77, 3, 5, 32'h77, 32'h11, 32'h55, 32'h11};
    vecs[10] = '{0, 0,  0, 0, 0, 0, 3, 6, 32'h77, 32'h22, 32'h77, 32'h22};
    #2;
    chk("reset_ready", {31'd0, ready_b}, 0);
    chk("reset_ready_nb", {31'd0, ready_n}, 0);
    chk("reset_rd", rd_b[31:0], 0);
    repeat (3) tick();
    reset = 1;
    wait_ready("init_sweep_cycles");
    check_all_zero("init_zero");
    tick();
    foreach (vecs[i]) begin
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
      #2;
      chk($sformatf("vec%0d_byp_rd0", i), rd_b[31:0], vecs[i].b0);
      chk($sformatf("vec%0d_byp_rd1", i), rd_b[63:32], vecs[i].b1);
      chk($sformatf("vec%0d_nobyp_rd0", i), rd_n[31:0], vecs[i].n0);
      chk($sformatf("vec%0d_nobyp_rd1", i), rd_n[63:32], vecs[i].n1);
      tick();
    end
    we0 = 0; we1 = 0;
    clear = 1; we0 = 1; wa0 = 3; wd0 = 32'h123; ra0 = 3;
    #2;
    chk("clear_cycle_no_bypass", rd_b[31:0], 32'h77);
    chk("clear_cycle_ready", {31'd0, ready_b}, 1);
    tick();
    clear = 0;
    chk("clear_ready_low", {31'd0, ready_b}, 0);
    we0 = 1; wa0 = 31; wd0 = 32'hFFFFFFFF; we1 = 1; wa1 = 3; wd1 = 32'hAAAA;
    ra0 = 31; ra1 = 3;
    #2;
    chk("sweep_rd0", rd_b[31:0], 0);
    chk("sweep_rd1", rd_b[63:32], 0);
    wait_ready("clear_sweep_cycles");
    we0 = 0; we1 = 0;
    check_all_zero("clear_zero");
    tick();
    we0 = 1; wa0 = 5; wd0 = 32'hCAFE; ra0 = 5;
    tick();
    we0 = 0;
    #1;
    chk("pre_reset_rd", rd_n[31:0], 32'hCAFE);
    reset = 0;
    #1;
    chk("async_reset_ready", {31'd0, ready_b}, 0);
    chk("async_reset_rd", rd_b[31:0], 0);
    tick();
    reset = 1;
    wait_ready("reset_run_sweep_cycles");
    #1;
    chk("reset_run_zeroed", rd_b[31:0], 0);
    tick();
    clear = 1;
    tick();
    clear = 0;
    repeat (10) tick();
    #2;
    reset = 0;
    #1;
    chk("mid_sweep_reset_ready", {31'd0, ready_b}, 0);
    chk("mid_sweep_reset_ready_nb", {31'd0, ready_n}, 0);
    tick();
    tick();
    reset = 1;
    wait_ready("mid_sweep_restart_cycles");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
